// File: rtl/shared_mem_ctrl_if.sv
// shared_mem_ctrl_if: system address width and the shared cache/memory request-response port.
package system_widths_pkg;
    localparam int ADDR_W = 16;
endpackage

interface cache_mem_if;
    import system_widths_pkg::*;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [7:0]        mem_req_write;
    logic              mem_resp_valid;
    logic [7:0]        mem_resp_data;
    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_write,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_write,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/shared_mem_ctrl.sv
// shared_mem_ctrl: single-outstanding byte memory responder with a fixed response latency.
module shared_mem_ctrl #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic       clk,
    input logic       resetN,
    cache_mem_if.slave mem_port
);
    localparam int IDX_W = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic [7:0] mem [DEPTH];
    logic [IDX_W-1:0] idx;
    logic       unused_addr;
    // Upper address bits are deliberately dropped so addresses wrap onto the array.
    assign idx         = mem_port.mem_req_addr[IDX_W-1:0];
    assign unused_addr = ^mem_port.mem_req_addr;
    assign mem_port.mem_req_ready = (state == IDLE);
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state                   <= IDLE;
            cnt                     <= '0;
            mem_port.mem_resp_valid <= 1'b0;
            mem_port.mem_resp_data  <= 8'h00;
            mem                     <= '{default: 8'h00};
        end else begin
            case (state)
                IDLE: if (mem_port.mem_req_valid) begin
                    if (mem_port.mem_req_we) mem[idx] <= mem_port.mem_req_write;
                    mem_port.mem_resp_data <= mem_port.mem_req_we ? mem_port.mem_req_write : mem[idx];
                    if (LATENCY == 1) begin
                        state                   <= RESP;
                        mem_port.mem_resp_valid <= 1'b1;
                    end else begin
                        state <= WAIT;
                        cnt   <= 4'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state                   <= RESP;
                        mem_port.mem_resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    state                   <= IDLE;
                    mem_port.mem_resp_valid <= 1'b0;
                end
                default: begin
                    state                   <= IDLE;
                    mem_port.mem_resp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shared_mem_ctrl.sv
// tb_shared_mem_ctrl: scoreboard bench for shared_mem_ctrl at LATENCY=2 and LATENCY=1.
module tb_shared_mem_ctrl;
    import system_widths_pkg::*;
    localparam int LAT = 2;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic [7:0] q[$];
    logic [7:0] model [256];
    cache_mem_if bus ();
    cache_mem_if bus1 ();
    shared_mem_ctrl #(.DEPTH(256), .LATENCY(LAT)) dut (.clk(clk), .resetN(resetN), .mem_port(bus));
    shared_mem_ctrl #(.DEPTH(256), .LATENCY(1)) dut1 (.clk(clk), .resetN(resetN), .mem_port(bus1));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk)
        if (resetN && bus.mem_resp_valid) begin
            if (q.size() == 0) chk("spurious_resp", 1, 0);
            else chk("resp_data", {24'h0, bus.mem_resp_data}, {24'h0, q.pop_front()});
        end
    task automatic do_reset();
        resetN = 1'b0;
        bus.mem_req_valid = 1'b0;
        q.delete();
        foreach (model[i]) model[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        chk("rst_ready", {31'h0, bus.mem_req_ready}, 1);
        chk("rst_resp_valid", {31'h0, bus.mem_resp_valid}, 0);
        chk("rst_resp_data", {24'h0, bus.mem_resp_data}, 0);
    endtask
    task automatic req(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        int c;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = we;
        bus.mem_req_addr  = a;
        bus.mem_req_write = d;
        c = 0;
        while (!bus.mem_req_ready && c < 20) begin @(posedge clk); #1 c++; end
        if (!bus.mem_req_ready) chk("ready_timeout", 0, 1);
        q.push_back(we ? d : model[a[7:0]]);
        if (we) model[a[7:0]] = d;
        @(posedge clk); #1;
        bus.mem_req_valid = 1'b0;
        c = 1;
        while (!bus.mem_resp_valid && c < 20) begin @(posedge clk); #1 c++; end
        chk("resp_latency", c, LAT);
        chk("ready_in_resp", {31'h0, bus.mem_req_ready}, 0);
        @(posedge clk); #1;
        chk("resp_one_cycle", {31'h0, bus.mem_resp_valid}, 0);
        chk("ready_after_resp", {31'h0, bus.mem_req_ready}, 1);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int last_acc, n_acc, n_resp;
        bus.mem_req_valid = 0; bus.mem_req_we = 0; bus.mem_req_addr = '0; bus.mem_req_write = 0;
        bus1.mem_req_valid = 0; bus1.mem_req_we = 0; bus1.mem_req_addr = '0; bus1.mem_req_write = 0;
        do_reset();
        req(1'b0, 16'h0042, 8'h00);
        req(1'b1, 16'h0010, 8'hA5);
        req(1'b0, 16'h0010, 8'h00);
        req(1'b1, 16'h0000, 8'h11);
        req(1'b1, 16'h00FF, 8'hEE);
        req(1'b0, 16'h0000, 8'h00);
        req(1'b0, 16'h00FF, 8'h00);
        req(1'b1, 16'h01FF, 8'h3C);
        req(1'b0, 16'h00FF, 8'h00);
        req(1'b0, 16'h0100, 8'h00);
        // Busy: keep valid high and change the request while the first one is in flight.
        bus.mem_req_valid = 1'b1; bus.mem_req_we = 1'b1; bus.mem_req_addr = 16'h0020; bus.mem_req_write = 8'h99;
        q.push_back(8'h99);
        model[8'h20] = 8'h99;
        @(posedge clk); #1;
        bus.mem_req_addr = 16'h0021; bus.mem_req_write = 8'h55;
        chk("busy_ready_wait", {31'h0, bus.mem_req_ready}, 0);
        @(posedge clk); #1;
        bus.mem_req_addr = 16'h0022;
        chk("busy_resp_valid", {31'h0, bus.mem_resp_valid}, 1);
        chk("busy_ready_resp", {31'h0, bus.mem_req_ready}, 0);
        @(posedge clk); #1;
        bus.mem_req_valid = 1'b0;
        chk("busy_resp_done", {31'h0, bus.mem_resp_valid}, 0);
        req(1'b0, 16'h0021, 8'h00);
        req(1'b0, 16'h0022, 8'h00);
        req(1'b0, 16'h0020, 8'h00);
        for (int i = 0; i < 12; i++)
            req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 8'($urandom));
        // Reset while the write is still waiting for its response.
        bus.mem_req_valid = 1'b1; bus.mem_req_we = 1'b1; bus.mem_req_addr = 16'h0005; bus.mem_req_write = 8'h77;
        @(posedge clk); #1;
        bus.mem_req_valid = 1'b0;
        resetN = 1'b0;
        q.delete();
        @(posedge clk); #1;
        chk("rst_wait_no_resp", {31'h0, bus.mem_resp_valid}, 0);
        do_reset();
        req(1'b0, 16'h0005, 8'h00);
        // LATENCY=1 back-to-back reads with valid held high.
        bus1.mem_req_valid = 1'b1;
        last_acc = -1; n_acc = 0; n_resp = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus1.mem_resp_valid) begin
                n_resp++;
                chk("l1_resp_after_acc", cyc, last_acc);
                chk("l1_data", {24'h0, bus1.mem_resp_data}, 0);
            end
            if (bus1.mem_req_ready) begin
                if (last_acc >= 0) chk("l1_acc_gap", cyc + 1 - last_acc, 2);
                last_acc = cyc + 1;
                n_acc++;
            end
            bus1.mem_req_addr = 16'($urandom);
        end
        bus1.mem_req_valid = 1'b0;
        chk("l1_acc_count", n_acc, 7);
        chk("l1_resp_count", n_resp, 7);
        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
